shift_seq_ctrl: RTL and testbench

//  Sequencer for the LED shift-register datapath. Owns a WIDTH-bit shift register.

---
 rtl/shift_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Burst shift-register sequencer for the LED datapath.
// Prescaler-paced shifts with start/stop/pause control and parallel load.
module shift_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 3000000,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [LEN_W-1:0] len,
    input  logic             dir,
    input  logic             rotate,
    input  logic             sin,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic             aborted
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [LEN_W-1:0] rem_q;
    logic             dir_q;
    logic             rot_q;
    logic             busy_q;
    logic             step_q;
    logic             done_q;
    logic             abort_q;
    logic             b_in;

    // Next shifted value using the direction/rotate latched at start
    always_comb begin
        b_in    = sin;
        shift_d = shreg_q;
        if (dir_q) begin
            b_in    = rot_q ? shreg_q[0] : sin;
            shift_d = {b_in, shreg_q[WIDTH-1:1]};
        end else begin
            b_in    = rot_q ? shreg_q[WIDTH-1] : sin;
            shift_d = {shreg_q[WIDTH-2:0], b_in};
        end
    end

    // Control FSM with prescaler, burst counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (load_en) begin
                        shreg_q <= load_data;
                    end
                    if (start) begin
                        if (len != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            rem_q   <= len;
                            dir_q   <= dir;
                            rot_q   <= rotate;
                            cnt_q   <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (stop) begin
                        // stop wins over any shift due this cycle
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                    end else if (pause) begin
                        state_q <= S_PAUSE;
                    end else begin
                        // leaving PAUSE counts in the same cycle so a
                        // pause of P cycles delays the burst by exactly P
                        state_q <= S_RUN;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            shreg_q <= shift_d;
                            step_q  <= 1'b1;
                            rem_q   <= rem_q - REM_ONE;
                            if (rem_q == REM_ONE) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q       = shreg_q;
    assign busy    = busy_q;
    assign step    = step_q;
    assign done    = done_q;
    assign aborted = abort_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl.
// PRESCALE=4, WIDTH=4; outputs sampled 1 time unit after each rising edge.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] len;
    logic       dir;
    logic       rotate;
    logic       sin;
    logic       load_en;
    logic [3:0] load_data;
    logic [3:0] q;
    logic       busy;
    logic       step;
    logic       done;
    logic       aborted;

    int errors;
    int checks;

    shift_seq_ctrl #(
        .WIDTH(4),
        .PRESCALE(4),
        .LEN_W(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .stop(stop),
        .pause(pause),
        .len(len),
        .dir(dir),
        .rotate(rotate),
        .sin(sin),
        .load_en(load_en),
        .load_data(load_data),
        .q(q),
        .busy(busy),
        .step(step),
        .done(done),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load_en   = 1'b1;
        load_data = v;
        cyc();
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({q, busy, step, done, aborted} !== 8'h00) begin
            errors++;
            $display("FAIL reset: q=%b busy=%b step=%b done=%b ab=%b want 0",
                     q, busy, step, done, aborted);
        end
        rstn = 1'b1;
        cyc();
    endtask

    // load 0001, len=3 left, sin=0
    task automatic test_basic_left();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'b0001;
        exp_q[1] = 4'b0010;
        exp_q[2] = 4'b0100;
        exp_q[3] = 4'b1000;
        do_load(4'b0001);
        checks++;
        if (q !== 4'b0001) begin
            errors++;
            $display("FAIL s1_load: q=%b want 0001", q);
        end
        start = 1'b1; len = 8'd3; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
        cyc();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL s1_busy_start: busy=%b want 1", busy);
        end
        for (int i = 1; i <= 12; i++) begin
            cyc();
            checks++;
            if (step !== (i % 4 == 0) || q !== exp_q[i/4]
                || done !== (i == 12) || busy !== (i < 12)) begin
                errors++;
                $display("FAIL s1_cyc%0d: step=%b q=%b done=%b busy=%b want %b %b %b %b",
                         i, step, q, done, busy, (i % 4 == 0),
                         exp_q[i/4], (i == 12), (i < 12));
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 4'b1000) begin
            errors++;
            $display("FAIL s1_after: busy=%b done=%b q=%b want 0 0 1000",
                     busy, done, q);
        end
    endtask

    // load+start coincident, len=5 right rotate from 1001
    task automatic test_rotate_right();
        logic [3:0] exp_q [6];
        int         ndone;
        exp_q[0] = 4'b1001;
        exp_q[1] = 4'b1100;
        exp_q[2] = 4'b0110;
        exp_q[3] = 4'b0011;
        exp_q[4] = 4'b1001;
        exp_q[5] = 4'b1100;
        ndone = 0;
        load_en = 1'b1; load_data = 4'b1001;
        start = 1'b1; len = 8'd5; dir = 1'b1; rotate = 1'b1; sin = 1'b0;
        cyc();
        load_en = 1'b0; start = 1'b0;
        len = 8'd1; dir = 1'b0; rotate = 1'b0;
        checks++;
        if (q !== 4'b1001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL s2_start: q=%b busy=%b want 1001 1", q, busy);
        end
        for (int i = 1; i <= 22; i++) begin
            cyc();
            if (done === 1'b1) ndone++;
            if (i <= 20) begin
                checks++;
                if (q !== exp_q[i/4] || step !== (i % 4 == 0)) begin
                    errors++;
                    $display("FAIL s2_cyc%0d: q=%b step=%b want %b %b",
                             i, q, step, exp_q[i/4], (i % 4 == 0));
                end
            end
            if (i == 20) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL s2_done: done=%b busy=%b want 1 0", done, busy);
                end
            end
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL s2_done_count: got %0d want 1", ndone);
        end
    endtask

    // stop coincident with third shift
    task automatic test_stop();
        do_load(4'b0001);
        start = 1'b1; len = 8'd6; dir = 1'b0; rotate = 1'b0; sin = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 11; i++) cyc();
        checks++;
        if (q !== 4'b0111 || busy !== 1'b1) begin
            errors++;
            $display("FAIL s3_two_shifts: q=%b busy=%b want 0111 1", q, busy);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (q !== 4'b0111 || step !== 1'b0 || aborted !== 1'b1
            || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s3_stop: q=%b step=%b ab=%b done=%b busy=%b want 0111 0 1 0 0",
                     q, step, aborted, done, busy);
        end
        cyc();
        checks++;
        if (aborted !== 1'b0 || q !== 4'b0111 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s3_after: ab=%b q=%b busy=%b want 0 0111 0",
                     aborted, q, busy);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL s3_idle_stop: ab=%b want 0", aborted);
        end
        sin = 1'b0;
    endtask

    // pause for 10 cycles between shifts
    task automatic test_pause();
        do_load(4'b0001);
        start = 1'b1; len = 8'd2; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) cyc();
        checks++;
        if (step !== 1'b1 || q !== 4'b0010) begin
            errors++;
            $display("FAIL s4_first: step=%b q=%b want 1 0010", step, q);
        end
        cyc();
        cyc();
        pause = 1'b1;
        for (int i = 7; i <= 16; i++) begin
            cyc();
            checks++;
            if (step !== 1'b0 || q !== 4'b0010 || busy !== 1'b1) begin
                errors++;
                $display("FAIL s4_paused%0d: step=%b q=%b busy=%b want 0 0010 1",
                         i, step, q, busy);
            end
        end
        pause = 1'b0;
        cyc();
        checks++;
        if (step !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL s4_c17: step=%b busy=%b want 0 1", step, busy);
        end
        cyc();
        checks++;
        if (step !== 1'b1 || q !== 4'b0100 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s4_c18: step=%b q=%b done=%b busy=%b want 1 0100 1 0",
                     step, q, done, busy);
        end
        cyc();
    endtask

    // len=0 start, then load_en while running
    task automatic test_len0_and_load_busy();
        do_load(4'b0101);
        start = 1'b1; len = 8'd0;
        cyc();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 4'b0101) begin
            errors++;
            $display("FAIL s5_len0: done=%b busy=%b q=%b want 1 0 0101",
                     done, busy, q);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL s5_len0_after: done=%b busy=%b want 0 0", done, busy);
        end
        start = 1'b1; len = 8'd1; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
        cyc();
        start = 1'b0;
        load_en = 1'b1; load_data = 4'b1111;
        cyc();
        load_en = 1'b0;
        checks++;
        if (q !== 4'b0101) begin
            errors++;
            $display("FAIL s5_load_busy: q=%b want 0101", q);
        end
        cyc();
        cyc();
        cyc();
        checks++;
        if (q !== 4'b1010 || done !== 1'b1 || step !== 1'b1) begin
            errors++;
            $display("FAIL s5_shift: q=%b done=%b step=%b want 1010 1 1",
                     q, done, step);
        end
        cyc();
    endtask

    // reset in the middle of a burst, then a clean burst
    task automatic test_reset_mid_burst();
        do_load(4'b0011);
        start = 1'b1; len = 8'd3; dir = 1'b0; rotate = 1'b0; sin = 1'b0;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) cyc();
        rstn = 1'b0;
        cyc();
        checks++;
        if ({q, busy, step, done, aborted} !== 8'h00) begin
            errors++;
            $display("FAIL s6_reset: q=%b busy=%b step=%b done=%b ab=%b want 0",
                     q, busy, step, done, aborted);
        end
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            checks++;
            if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin
                errors++;
                $display("FAIL s6_quiet%0d: done=%b ab=%b busy=%b q=%b want 0 0 0 0000",
                         i, done, aborted, busy, q);
            end
        end
        test_basic_left();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        len = 8'd0;
        dir = 1'b0;
        rotate = 1'b0;
        sin = 1'b0;
        load_en = 1'b0;
        load_data = 4'b0000;
        test_reset();
        test_basic_left();
        test_rotate_right();
        test_stop();
        test_pause();
        test_len0_and_load_busy();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
